hit_resolver: RTL and testbench

Frame-rate combat resolver that sits between the two fighters' `player_move`/`player_attack` blocks and their `player_state_anim` instances. It closes the attacker-to-defender path: each frame it checks each player's active attack hitbox against the opponent's hurtbox, and registers at most one hit per attack. On a hit it decrements the defender's health, loads the defender's hitstun counter and reports knockback direction. It drives the `hitstun_active` input of both animation FSMs and declares KO.

---
 rtl/fighter_pkg.sv | 47 ++++
 rtl/hit_resolver_if.sv | 28 ++
 rtl/box_overlap.sv | 21 ++
 rtl/hit_resolver.sv | 198 +++++++++++++++++++
 tb/tb_hit_resolver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fighter_pkg.sv
// Shared fighter constants, geometry offsets, FSM states and the snapshot/box
// types used by the combat resolver and the debug overlay.
package fighter_pkg;

  localparam int MAX_HP         = 100;
  localparam int DMG            = 10;
  localparam int HITSTUN_FRAMES = 20;

  // Sprite width; the left-facing hitbox is the right-facing one mirrored about it.
  localparam int SPRITE_W  = 120;
  localparam int HIT_XOFF  = 85;
  localparam int HIT_W     = 40;
  localparam int HIT_YOFF  = -5;
  localparam int HIT_H     = 80;
  localparam int HURT_XOFF = 40;
  localparam int HURT_W    = 40;
  localparam int HURT_YOFF = 53;
  localparam int HURT_H    = 45;

  localparam int POS_W   = 10;
  localparam int COORD_W = 11;
  localparam int HP_W    = 8;
  localparam int HS_W    = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EVAL  = 2'd1,
    S_APPLY = 2'd2,
    S_KO    = 2'd3
  } fsm_state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic             facing;
    logic             dmg;
  } player_snap_t;

  // Edges are two's-complement COORD_W-bit values; consumers compare them signed.
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] y1;
  } box_t;

endpackage

// File: rtl/hit_resolver_if.sv
// Frame-level signal bundle between the fighters' move/attack logic, the
// animation FSMs and the hit resolver.
interface hit_resolver_if;
  import fighter_pkg::*;

  logic             SCEN;
  logic [POS_W-1:0] p1_x, p1_y, p2_x, p2_y;
  logic             p1_facing, p2_facing;
  logic             p1_dmg, p2_dmg;
  logic [HP_W-1:0]  p1_hp, p2_hp;
  logic             p1_hitstun, p2_hitstun;
  logic             p1_hit, p2_hit;
  logic             p1_kb_right, p2_kb_right;
  logic             ko;
  logic             winner;

  modport slave (
    input  SCEN, p1_x, p1_y, p2_x, p2_y, p1_facing, p2_facing, p1_dmg, p2_dmg,
    output p1_hp, p2_hp, p1_hitstun, p2_hitstun, p1_hit, p2_hit,
           p1_kb_right, p2_kb_right, ko, winner
  );

  modport master (
    output SCEN, p1_x, p1_y, p2_x, p2_y, p1_facing, p2_facing, p1_dmg, p2_dmg,
    input  p1_hp, p2_hp, p1_hitstun, p2_hitstun, p1_hit, p2_hit,
           p1_kb_right, p2_kb_right, ko, winner
  );
endinterface

// File: rtl/box_overlap.sv
// Combinational half-open AABB intersection test on signed 11-bit box edges.
module box_overlap
  import fighter_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);
  logic signed [COORD_W-1:0] ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;

  assign ax0 = $signed(a.x0);
  assign ax1 = $signed(a.x1);
  assign ay0 = $signed(a.y0);
  assign ay1 = $signed(a.y1);
  assign bx0 = $signed(b.x0);
  assign bx1 = $signed(b.x1);
  assign by0 = $signed(b.y0);
  assign by1 = $signed(b.y1);

  assign hit = (ax0 < bx1) && (bx0 < ax1) && (ay0 < by1) && (by0 < ay1);
endmodule

// File: rtl/hit_resolver.sv
// Per-frame combat resolver: snapshots both fighters on SCEN, tests hitbox vs
// hurtbox both ways, then applies damage, hitstun, knockback and KO.
module hit_resolver #(
  parameter int MAX_HP         = fighter_pkg::MAX_HP,
  parameter int DMG            = fighter_pkg::DMG,
  parameter int HITSTUN_FRAMES = fighter_pkg::HITSTUN_FRAMES,
  parameter int HIT_XOFF       = fighter_pkg::HIT_XOFF,
  parameter int HIT_W          = fighter_pkg::HIT_W,
  parameter int HIT_YOFF       = fighter_pkg::HIT_YOFF,
  parameter int HIT_H          = fighter_pkg::HIT_H,
  parameter int HURT_XOFF      = fighter_pkg::HURT_XOFF,
  parameter int HURT_W         = fighter_pkg::HURT_W,
  parameter int HURT_YOFF      = fighter_pkg::HURT_YOFF,
  parameter int HURT_H         = fighter_pkg::HURT_H
) (
  input logic           clk,
  input logic           reset,
  hit_resolver_if.slave bus
);
  import fighter_pkg::*;

  localparam logic signed [COORD_W-1:0] HIT_DX_R = COORD_W'(HIT_XOFF);
  localparam logic signed [COORD_W-1:0] HIT_DX_L = COORD_W'(SPRITE_W - HIT_XOFF - HIT_W);
  localparam logic signed [COORD_W-1:0] HIT_DY   = COORD_W'(HIT_YOFF);
  localparam logic signed [COORD_W-1:0] HIT_WS   = COORD_W'(HIT_W);
  localparam logic signed [COORD_W-1:0] HIT_HS   = COORD_W'(HIT_H);
  localparam logic signed [COORD_W-1:0] HURT_DX  = COORD_W'(HURT_XOFF);
  localparam logic signed [COORD_W-1:0] HURT_DY  = COORD_W'(HURT_YOFF);
  localparam logic signed [COORD_W-1:0] HURT_WS  = COORD_W'(HURT_W);
  localparam logic signed [COORD_W-1:0] HURT_HS  = COORD_W'(HURT_H);

  function automatic box_t hitbox(input player_snap_t p);
    logic signed [COORD_W-1:0] xs, ys, x0, y0;
    box_t b;
    xs = $signed({1'b0, p.x});
    ys = $signed({1'b0, p.y});
    x0 = p.facing ? (xs + HIT_DX_R) : (xs + HIT_DX_L);
    y0 = ys + HIT_DY;
    b.x0 = x0;
    b.x1 = x0 + HIT_WS;
    b.y0 = y0;
    b.y1 = y0 + HIT_HS;
    return b;
  endfunction

  function automatic box_t hurtbox(input player_snap_t p);
    logic signed [COORD_W-1:0] x0, y0;
    box_t b;
    x0 = $signed({1'b0, p.x}) + HURT_DX;
    y0 = $signed({1'b0, p.y}) + HURT_DY;
    b.x0 = x0;
    b.x1 = x0 + HURT_WS;
    b.y0 = y0;
    b.y1 = y0 + HURT_HS;
    return b;
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
    return (hp > HP_W'(DMG)) ? (hp - HP_W'(DMG)) : '0;
  endfunction

  fsm_state_t      state_q, state_d;
  player_snap_t    snap1_q, snap1_d, snap2_q, snap2_d;
  logic            ov12_q, ov12_d, ov21_q, ov21_d;
  logic [HP_W-1:0] hp1_q, hp1_d, hp2_q, hp2_d;
  logic [HS_W-1:0] hs1_q, hs1_d, hs2_q, hs2_d;
  logic            done1_q, done1_d, done2_q, done2_d;
  logic            hit1_q, hit1_d, hit2_q, hit2_d;
  logic            kb1_q, kb1_d, kb2_q, kb2_d;
  logic            winner_q, winner_d;
  logic            ov12_w, ov21_w, land12, land21;
  box_t            hit1_box, hit2_box, hurt1_box, hurt2_box;

  assign hit1_box  = hitbox(snap1_q);
  assign hit2_box  = hitbox(snap2_q);
  assign hurt1_box = hurtbox(snap1_q);
  assign hurt2_box = hurtbox(snap2_q);

  box_overlap u_ov12 (.a(hit1_box), .b(hurt2_box), .hit(ov12_w));
  box_overlap u_ov21 (.a(hit2_box), .b(hurt1_box), .hit(ov21_w));

  // Validity uses pre-update hitstun so a trade lands both hits.
  assign land12 = snap1_q.dmg && ov12_q && !done1_q && (hs1_q == '0);
  assign land21 = snap2_q.dmg && ov21_q && !done2_q && (hs2_q == '0);

  always_comb begin
    state_d  = state_q;
    snap1_d  = snap1_q;
    snap2_d  = snap2_q;
    ov12_d   = ov12_q;
    ov21_d   = ov21_q;
    hp1_d    = hp1_q;
    hp2_d    = hp2_q;
    hs1_d    = hs1_q;
    hs2_d    = hs2_q;
    done1_d  = done1_q;
    done2_d  = done2_q;
    hit1_d   = 1'b0;
    hit2_d   = 1'b0;
    kb1_d    = kb1_q;
    kb2_d    = kb2_q;
    winner_d = winner_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.SCEN) begin
          snap1_d = '{x: bus.p1_x, y: bus.p1_y, facing: bus.p1_facing, dmg: bus.p1_dmg};
          snap2_d = '{x: bus.p2_x, y: bus.p2_y, facing: bus.p2_facing, dmg: bus.p2_dmg};
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        ov12_d  = ov12_w;
        ov21_d  = ov21_w;
        state_d = S_APPLY;
      end
      S_APPLY: begin
        if (land12) begin
          hp2_d   = sat_sub(hp2_q);
          hs2_d   = HS_W'(HITSTUN_FRAMES);
          kb2_d   = snap1_q.facing;
          hit2_d  = 1'b1;
          done1_d = 1'b1;
        end else if (hs2_q != '0) begin
          hs2_d = hs2_q - HS_W'(1);
        end
        if (land21) begin
          hp1_d   = sat_sub(hp1_q);
          hs1_d   = HS_W'(HITSTUN_FRAMES);
          kb1_d   = snap2_q.facing;
          hit1_d  = 1'b1;
          done2_d = 1'b1;
        end else if (hs1_q != '0) begin
          hs1_d = hs1_q - HS_W'(1);
        end
        // Releasing the attack button re-arms the next hit.
        if (!snap1_q.dmg) done1_d = 1'b0;
        if (!snap2_q.dmg) done2_d = 1'b0;
        if ((hp1_d == '0) || (hp2_d == '0)) begin
          winner_d = (hp1_d == '0) && (hp2_d != '0);
          state_d  = S_KO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_KO: state_d = S_KO;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      hp1_q    <= HP_W'(MAX_HP);
      hp2_q    <= HP_W'(MAX_HP);
      hs1_q    <= '0;
      hs2_q    <= '0;
      done1_q  <= 1'b0;
      done2_q  <= 1'b0;
      hit1_q   <= 1'b0;
      hit2_q   <= 1'b0;
      kb1_q    <= 1'b0;
      kb2_q    <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hp1_q    <= hp1_d;
      hp2_q    <= hp2_d;
      hs1_q    <= hs1_d;
      hs2_q    <= hs2_d;
      done1_q  <= done1_d;
      done2_q  <= done2_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      kb1_q    <= kb1_d;
      kb2_q    <= kb2_d;
      winner_q <= winner_d;
    end
  end

  // Snapshot and overlap results are only consumed in the frame that loads them.
  always_ff @(posedge clk) begin
    snap1_q <= snap1_d;
    snap2_q <= snap2_d;
    ov12_q  <= ov12_d;
    ov21_q  <= ov21_d;
  end

  assign bus.p1_hp       = hp1_q;
  assign bus.p2_hp       = hp2_q;
  assign bus.p1_hitstun  = (hs1_q != '0);
  assign bus.p2_hitstun  = (hs2_q != '0);
  assign bus.p1_hit      = hit1_q;
  assign bus.p2_hit      = hit2_q;
  assign bus.p1_kb_right = kb1_q;
  assign bus.p2_kb_right = kb2_q;
  assign bus.ko          = (state_q == S_KO);
  assign bus.winner      = winner_q;
endmodule

// File: tb/tb_hit_resolver.sv
// Bench for hit_resolver: frame-level reference model with a cycle-accurate
// output scoreboard, directed scenarios with literal expectations, random frames.
module tb_hit_resolver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  hit_resolver_if bus();
  hit_resolver dut (.clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    int due;
    int hp1, hp2, hs1, hs2;
    bit kb1, kb2, hit1, hit2, ko, winner;
  } exp_t;

  exp_t q[$];
  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  int m_hp1, m_hp2, m_hs1, m_hs2;
  bit m_done1, m_done2, m_kb1, m_kb2, m_ko, m_winner;
  int e_hp1, e_hp2, e_hs1, e_hs2;
  bit e_kb1, e_kb2, e_hit1, e_hit2, e_ko, e_winner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Hitbox of attacker a (facing af) against hurtbox of defender b.
  function automatic bit overlaps(int ax, int ay, bit af, int bx, int by);
    int hx0;
    hx0 = af ? ax + 85 : ax - 5;
    return (hx0 < bx + 80) && (bx + 40 < hx0 + 40) && (ay - 5 < by + 98) && (by + 53 < ay + 75);
  endfunction

  function automatic void model_reset();
    m_hp1 = 100; m_hp2 = 100; m_hs1 = 0; m_hs2 = 0;
    m_done1 = 0; m_done2 = 0; m_kb1 = 0; m_kb2 = 0; m_ko = 0; m_winner = 0;
    e_hp1 = 100; e_hp2 = 100; e_hs1 = 0; e_hs2 = 0;
    e_kb1 = 0; e_kb2 = 0; e_hit1 = 0; e_hit2 = 0; e_ko = 0; e_winner = 0;
    q.delete();
  endfunction

  function automatic void model_frame(int x1, int y1, bit f1, bit d1, int x2, int y2, bit f2, bit d2);
    exp_t e;
    bit v12, v21;
    if (m_ko) return;
    v12 = d1 && overlaps(x1, y1, f1, x2, y2) && !m_done1 && (m_hs1 == 0);
    v21 = d2 && overlaps(x2, y2, f2, x1, y1) && !m_done2 && (m_hs2 == 0);
    if (v12) begin
      m_hp2 = (m_hp2 > 10) ? m_hp2 - 10 : 0; m_hs2 = 20; m_kb2 = f1; m_done1 = 1;
    end else if (m_hs2 > 0) m_hs2--;
    if (v21) begin
      m_hp1 = (m_hp1 > 10) ? m_hp1 - 10 : 0; m_hs1 = 20; m_kb1 = f2; m_done2 = 1;
    end else if (m_hs1 > 0) m_hs1--;
    if (!d1) m_done1 = 0;
    if (!d2) m_done2 = 0;
    if (m_hp1 == 0 || m_hp2 == 0) begin
      m_ko = 1;
      m_winner = (m_hp1 == 0) && (m_hp2 != 0);
    end
    e.due = cyc + 3;
    e.hp1 = m_hp1; e.hp2 = m_hp2; e.hs1 = m_hs1; e.hs2 = m_hs2;
    e.kb1 = m_kb1; e.kb2 = m_kb2; e.hit1 = v21; e.hit2 = v12;
    e.ko = m_ko; e.winner = m_winner;
    q.push_back(e);
  endfunction

  // Scoreboard: outputs checked every cycle against the model's scheduled results.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      e_hit1 = 0;
      e_hit2 = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e_hp1 = q[0].hp1; e_hp2 = q[0].hp2; e_hs1 = q[0].hs1; e_hs2 = q[0].hs2;
        e_kb1 = q[0].kb1; e_kb2 = q[0].kb2; e_hit1 = q[0].hit1; e_hit2 = q[0].hit2;
        e_ko = q[0].ko; e_winner = q[0].winner;
        void'(q.pop_front());
      end
      if (chk_en) begin
        chk("p1_hp", bus.p1_hp, e_hp1);
        chk("p2_hp", bus.p2_hp, e_hp2);
        chk("p1_hitstun", bus.p1_hitstun, (e_hs1 != 0));
        chk("p2_hitstun", bus.p2_hitstun, (e_hs2 != 0));
        chk("p1_hit", bus.p1_hit, e_hit1);
        chk("p2_hit", bus.p2_hit, e_hit2);
        chk("p1_kb_right", bus.p1_kb_right, e_kb1);
        chk("p2_kb_right", bus.p2_kb_right, e_kb2);
        chk("ko", bus.ko, e_ko);
        if (e_ko) chk("winner", bus.winner, e_winner);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_inputs(int x1, int y1, bit f1, bit d1, int x2, int y2, bit f2, bit d2);
    bus.p1_x = 10'(x1); bus.p1_y = 10'(y1); bus.p1_facing = f1; bus.p1_dmg = d1;
    bus.p2_x = 10'(x2); bus.p2_y = 10'(y2); bus.p2_facing = f2; bus.p2_dmg = d2;
  endtask

  // Returns at the negedge of cycle t+gap (gap >= 3), where t is the SCEN cycle.
  task automatic frame(int x1, int y1, bit f1, bit d1, int x2, int y2, bit f2, bit d2,
                       int gap, bit extra, bit scramble);
    set_inputs(x1, y1, f1, d1, x2, y2, f2, d2);
    bus.SCEN = 1'b1;
    model_frame(x1, y1, f1, d1, x2, y2, f2, d2);
    @(negedge clk);
    bus.SCEN = extra;
    if (scramble)
      set_inputs($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom),
                 1'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 1'($urandom), 1'($urandom));
    @(negedge clk);
    bus.SCEN = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic p1_attack(bit d);
    frame(200, 250, 1, d, 260, 250, 0, 0, 3, 0, 0);
  endtask

  initial begin
    int hits;
    bus.SCEN = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    chk_en = 1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_p1_hp", bus.p1_hp, 100);
    chk("reset_p2_hp", bus.p2_hp, 100);
    chk("reset_ko", bus.ko, 0);

    // Basic hit
    p1_attack(1);
    chk("basic_p2_hit", bus.p2_hit, 1);
    chk("basic_p2_hp", bus.p2_hp, 90);
    chk("basic_p2_hitstun", bus.p2_hitstun, 1);
    chk("basic_p2_kb", bus.p2_kb_right, 1);
    @(negedge clk);
    chk("basic_pulse_one_cycle", bus.p2_hit, 0);

    // Hitbox right edge: x1=325, hurtbox x0 = p2_x+40
    do_reset();
    frame(200, 250, 1, 1, 284, 250, 0, 0, 3, 0, 0);
    chk("edge_284_hit", bus.p2_hit, 1);
    do_reset();
    frame(200, 250, 1, 1, 285, 250, 0, 0, 3, 0, 0);
    chk("edge_285_nohit", bus.p2_hit, 0);
    chk("edge_285_hp", bus.p2_hp, 100);

    // Negative hitbox y near the top of the screen
    do_reset();
    frame(200, 0, 1, 1, 260, 0, 0, 0, 3, 0, 0);
    chk("neg_y_hit", bus.p2_hit, 1);

    // One hit per attack window
    do_reset();
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      p1_attack(1);
      hits += int'(bus.p2_hit);
    end
    chk("one_hit_per_window", hits, 1);
    p1_attack(0);
    p1_attack(1);
    chk("rearm_hp", bus.p2_hp, 80);

    // Hitstun duration
    do_reset();
    p1_attack(1);
    for (int i = 1; i <= 19; i++) p1_attack(0);
    chk("hitstun_frame19", bus.p2_hitstun, 1);
    p1_attack(0);
    chk("hitstun_frame20", bus.p2_hitstun, 0);

    // Hitstun reload at frame 10
    do_reset();
    p1_attack(1);
    for (int i = 1; i <= 9; i++) p1_attack(0);
    p1_attack(1);
    chk("reload_hit", bus.p2_hit, 1);
    for (int i = 11; i <= 29; i++) p1_attack(0);
    chk("reload_frame29", bus.p2_hitstun, 1);
    p1_attack(0);
    chk("reload_frame30", bus.p2_hitstun, 0);

    // Trade
    do_reset();
    frame(200, 250, 1, 1, 260, 250, 0, 1, 3, 0, 0);
    chk("trade_p1_hit", bus.p1_hit, 1);
    chk("trade_p2_hit", bus.p2_hit, 1);
    chk("trade_p1_hp", bus.p1_hp, 90);
    chk("trade_p2_hp", bus.p2_hp, 90);
    chk("trade_p1_kb", bus.p1_kb_right, 0);
    chk("trade_p2_kb", bus.p2_kb_right, 1);

    // KO of P2
    do_reset();
    for (int i = 0; i < 10; i++) begin
      p1_attack(1);
      p1_attack(0);
    end
    chk("ko_p2_hp", bus.p2_hp, 0);
    chk("ko_flag", bus.ko, 1);
    chk("ko_winner_p1", bus.winner, 0);
    frame(200, 250, 1, 1, 260, 250, 0, 1, 3, 0, 0);
    frame(200, 250, 1, 0, 260, 250, 0, 1, 4, 1, 0);
    chk("ko_frozen_p1_hp", bus.p1_hp, 100);
    chk("ko_frozen_p2_hp", bus.p2_hp, 0);

    // KO of P1
    do_reset();
    for (int i = 0; i < 10; i++) begin
      frame(200, 250, 1, 0, 260, 250, 0, 1, 3, 0, 0);
      frame(200, 250, 1, 0, 260, 250, 0, 0, 3, 0, 0);
    end
    chk("ko_p1_hp", bus.p1_hp, 0);
    chk("ko_winner_p2", bus.winner, 1);

    // Reset asserted during APPLY of a hit frame
    do_reset();
    set_inputs(200, 250, 1, 1, 260, 250, 0, 0);
    bus.SCEN = 1'b1;
    @(negedge clk);
    bus.SCEN = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midreset_hp_now", bus.p2_hp, 100);
    @(negedge clk);
    chk("midreset_no_pulse", bus.p2_hit, 0);
    chk("midreset_hp", bus.p2_hp, 100);
    reset = 1'b0;
    @(negedge clk);

    // Random frames
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int x1, y1, x2, y2;
      x1 = $urandom_range(100, 400);
      y1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(230, 270);
      x2 = x1 + $urandom_range(0, 200) - 100;
      y2 = y1 + $urandom_range(0, 40) - 20;
      if (y2 < 0) y2 = 0;
      frame(x1, y1, 1'($urandom), 1'($urandom), x2, y2, 1'($urandom), 1'($urandom),
            $urandom_range(3, 5), 1'($urandom), 1);
      if (m_ko) begin
        frame(x1, y1, 1, 1, x2, y2, 0, 1, 3, 0, 0);
        do_reset();
      end
    end
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
